// File: rtl/booth_seq_pkg.sv
// Shared types for the Booth multiplier sequencer: FSM states, product width
// and the operand-pair entry stored in the FIFO.
package booth_seq_pkg;

    localparam int DATA_W = 8;
    localparam int PROD_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic signed [DATA_W-1:0] a;
        logic signed [DATA_W-1:0] b;
    } operand_t;

endpackage

// File: rtl/booth_mul_sequencer_if.sv
// Producer, multiplier and consumer signals of the sequencer in one bundle.
// Handshakes: a transfer happens on a rising clk edge where valid && ready.
interface booth_mul_sequencer_if
    import booth_seq_pkg::*;
#(
    parameter int DATAWIDTH  = 8,
    parameter int FIFO_DEPTH = 4
) ();

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    logic                          in_valid;
    logic                          in_ready;
    logic signed [DATAWIDTH-1:0]   in_a;
    logic signed [DATAWIDTH-1:0]   in_b;

    logic                          mul_start;
    logic signed [DATAWIDTH-1:0]   mul_a;
    logic signed [DATAWIDTH-1:0]   mul_b;
    logic signed [2*DATAWIDTH-1:0] mul_product;
    logic                          mul_done;

    logic                          out_valid;
    logic                          out_ready;
    logic signed [2*DATAWIDTH-1:0] out_product;
    logic                          out_timeout;

    logic [CW-1:0]                 fifo_count;
    seq_state_e                    dbg_state;

    modport slave (
        input  in_valid, in_a, in_b, mul_product, mul_done, out_ready,
        output in_ready, mul_start, mul_a, mul_b, out_valid, out_product,
               out_timeout, fifo_count, dbg_state
    );

    modport master (
        output in_valid, in_a, in_b, mul_product, mul_done, out_ready,
        input  in_ready, mul_start, mul_a, mul_b, out_valid, out_product,
               out_timeout, fifo_count, dbg_state
    );

endinterface

// File: rtl/booth_operand_fifo.sv
// Small synchronous FIFO of operand pairs; depth must be a power of two so
// the pointers wrap naturally.
module booth_operand_fifo #(
    parameter  int DATAWIDTH  = 8,
    parameter  int FIFO_DEPTH = 4,
    localparam int EW = 2 * DATAWIDTH,
    localparam int AW = $clog2(FIFO_DEPTH),
    localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [EW-1:0] wdata_i,
    input  logic          pop_i,
    output logic [EW-1:0] rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [EW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == CW'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full FIFO is dropped, never overwrites.
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

endmodule

// File: rtl/booth_mul_sequencer.sv
// Feeds queued operand pairs to booth_multiplier one at a time and returns
// each product (or a timeout marker) on a valid/ready output, in order.
module booth_mul_sequencer
    import booth_seq_pkg::*;
#(
    parameter int DATAWIDTH  = DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 64
) (
    input logic                  clk,
    input logic                  rst_overall,
    booth_mul_sequencer_if.slave bus
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    seq_state_e                    state_q, state_d;
    logic                          mul_start_q, mul_start_d;
    logic signed [DATAWIDTH-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic                          out_valid_q, out_valid_d;
    logic signed [2*DATAWIDTH-1:0] out_product_q, out_product_d;
    logic                          out_timeout_q, out_timeout_d;
    logic                          done_q;
    logic [TW-1:0]                 timer_q, timer_d;

    operand_t wr_entry, head;
    logic     fifo_pop, fifo_full, fifo_empty;
    logic     completion;

    assign wr_entry.a = bus.in_a;
    assign wr_entry.b = bus.in_b;

    booth_operand_fifo #(
        .DATAWIDTH (DATAWIDTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst_overall),
        .push_i (bus.in_valid),
        .wdata_i(wr_entry),
        .pop_i  (fifo_pop),
        .rdata_o(head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(bus.fifo_count)
    );

    // Only a fresh rising edge of done counts; a level left over from the
    // previous operation must drop first.
    assign completion = bus.mul_done && !done_q;

    always_comb begin
        state_d       = state_q;
        mul_start_d   = 1'b0;
        mul_a_d       = mul_a_q;
        mul_b_d       = mul_b_q;
        out_valid_d   = out_valid_q;
        out_product_d = out_product_q;
        out_timeout_d = out_timeout_q;
        timer_d       = timer_q;
        fifo_pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    mul_a_d  = head.a;
                    mul_b_d  = head.b;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                mul_start_d = 1'b1;
                timer_d     = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                if (completion) begin
                    out_product_d = bus.mul_product;
                    out_timeout_d = 1'b0;
                    out_valid_d   = 1'b1;
                    state_d       = HOLD;
                end else if (timer_q == TIMER_LAST) begin
                    out_product_d = '0;
                    out_timeout_d = 1'b1;
                    out_valid_d   = 1'b1;
                    state_d       = HOLD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        mul_a_d  = head.a;
                        mul_b_d  = head.b;
                        state_d  = ISSUE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_overall) begin
        if (rst_overall) begin
            state_q       <= IDLE;
            mul_start_q   <= 1'b0;
            mul_a_q       <= '0;
            mul_b_q       <= '0;
            out_valid_q   <= 1'b0;
            out_product_q <= '0;
            out_timeout_q <= 1'b0;
            done_q        <= 1'b0;
            timer_q       <= '0;
        end else begin
            state_q       <= state_d;
            mul_start_q   <= mul_start_d;
            mul_a_q       <= mul_a_d;
            mul_b_q       <= mul_b_d;
            out_valid_q   <= out_valid_d;
            out_product_q <= out_product_d;
            out_timeout_q <= out_timeout_d;
            done_q        <= bus.mul_done;
            timer_q       <= timer_d;
        end
    end

    assign bus.in_ready    = !fifo_full;
    assign bus.mul_start   = mul_start_q;
    assign bus.mul_a       = mul_a_q;
    assign bus.mul_b       = mul_b_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_product = out_product_q;
    assign bus.out_timeout = out_timeout_q;
    assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_booth_mul_sequencer.sv
// Directed bench for booth_mul_sequencer with a behavioural multiplier and an
// in-order result scoreboard.
module tb_booth_mul_sequencer;
    import booth_seq_pkg::*;

    localparam int DW      = 8;
    localparam int PW      = 2 * DW;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    booth_mul_sequencer_if #(.DATAWIDTH(DW), .FIFO_DEPTH(DEPTH)) bus ();

    booth_mul_sequencer #(
        .DATAWIDTH (DW),
        .FIFO_DEPTH(DEPTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_overall(rst),
        .bus        (bus)
    );

    // Multiplier model: done pulses 4 cycles after start; the bench can take
    // over mul_done entirely with ovr_en to create stuck or level-done cases.
    logic                 model_done, ovr_en, ovr_done, mbusy;
    logic signed [PW-1:0] model_prod;
    logic signed [DW-1:0] ma, mb;
    int unsigned          mcnt;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_done <= 1'b0;
            mbusy      <= 1'b0;
            mcnt       <= 0;
            model_prod <= '0;
        end else begin
            model_done <= 1'b0;
            if (bus.mul_start) begin
                mbusy <= 1'b1;
                mcnt  <= 3;
                ma    <= bus.mul_a;
                mb    <= bus.mul_b;
            end else if (mbusy) begin
                if (mcnt == 0) begin
                    mbusy      <= 1'b0;
                    model_done <= 1'b1;
                    model_prod <= ma * mb;
                end else begin
                    mcnt <= mcnt - 1;
                end
            end
        end
    end

    assign bus.mul_done    = ovr_en ? ovr_done : model_done;
    assign bus.mul_product = model_prod;

    // Scoreboard
    logic [PW:0] exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          start_cnt = 0;
    logic        start_prev = 1'b0;
    logic [PW:0] mon_e;

    function automatic void chk(input string name, input logic signed [63:0] act,
                                input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endfunction

    function automatic logic [PW:0] res(input int p);
        return {1'b0, PW'(p)};
    endfunction

    always @(negedge clk) begin
        #1;
        if (!rst) begin
            if (bus.out_valid && bus.out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got product %0d timeout %0b, none expected",
                             bus.out_product, bus.out_timeout);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({bus.out_timeout, bus.out_product} !== mon_e) begin
                        errors++;
                        $display("FAIL result: got product %0d timeout %0b expected product %0d timeout %0b",
                                 bus.out_product, bus.out_timeout, $signed(mon_e[PW-1:0]), mon_e[PW]);
                    end
                end
            end
            if (bus.mul_start) begin
                start_cnt++;
                checks++;
                if (start_prev) begin
                    errors++;
                    $display("FAIL start_width: got 2+ cycle mul_start expected 1 cycle");
                end
            end
            start_prev = bus.mul_start;
        end else begin
            start_prev = 1'b0;
        end
    end

    // Driver tasks (called on a falling edge, return on a falling edge)
    task automatic push_op(input logic signed [DW-1:0] a, input logic signed [DW-1:0] b,
                           input logic [PW:0] exp, input bit track);
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        while (!bus.in_ready && waited < 300) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_stall: got in_ready 0 for %0d cycles expected acceptance", waited);
            bus.in_valid = 1'b0;
            return;
        end
        if (track) exp_q.push_back(exp);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        while (!bus.mul_start && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, bus.mul_start, 1);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(name, exp_q.size(), 0);
    endtask

    typedef struct {
        logic signed [DW-1:0] a;
        logic signed [DW-1:0] b;
        int                   p;
    } vec_t;

    vec_t t2[4] = '{'{-5, 3, -15}, '{5, -3, -15}, '{-5, -3, 15}, '{127, -128, -16256}};
    vec_t t3[6] = '{'{1, 1, 1}, '{2, -2, -4}, '{-3, 3, -9}, '{4, 4, 16},
                    '{-7, -7, 49}, '{100, 100, 10000}};

    logic [3:0]           s;
    logic signed [DW-1:0] sa, sb;
    int                   n, cnt0, highs;

    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        ovr_en        = 1'b0;
        ovr_done      = 1'b0;
        repeat (3) @(negedge clk);

        chk("rst_fifo_count", bus.fifo_count, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_mul_start", bus.mul_start, 0);
        chk("rst_mul_a", bus.mul_a, 0);
        chk("rst_out_product", bus.out_product, 0);
        chk("rst_out_timeout", bus.out_timeout, 0);
        chk("rst_state", bus.dbg_state, IDLE);
        rst = 1'b0;
        @(negedge clk);

        // Single op: start latency, operands, done-to-valid latency
        bus.out_ready = 1'b1;
        push_op(5, 3, res(15), 1);
        s[0] = bus.mul_start;
        for (int i = 1; i < 4; i++) begin
            @(negedge clk);
            s[i] = bus.mul_start;
            if (i == 2) begin
                sa = bus.mul_a;
                sb = bus.mul_b;
            end
        end
        chk("t1_start_pattern", s, 4'b0100);
        chk("t1_mul_a", sa, 5);
        chk("t1_mul_b", sb, 3);
        n = 0;
        while (!bus.mul_done && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t1_done_seen", bus.mul_done, 1);
        chk("t1_valid_before", bus.out_valid, 0);
        @(negedge clk);
        chk("t1_valid_after", bus.out_valid, 1);
        wait_drain("t1_drain");

        // Sign combinations and extremes, back to back
        cnt0 = start_cnt;
        foreach (t2[i]) push_op(t2[i].a, t2[i].b, res(t2[i].p), 1);
        wait_drain("t2_drain");
        chk("t2_start_count", start_cnt - cnt0, 4);

        // Backpressure: fill FIFO behind a held result
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_op(t3[i].a, t3[i].b, res(t3[i].p), 1);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        fork
            push_op(t3[5].a, t3[5].b, res(t3[5].p), 1);
        join_none
        repeat (4) @(negedge clk);
        chk("t3_fifo_full_count", bus.fifo_count, 4);
        chk("t3_in_ready_low", bus.in_ready, 0);
        chk("t3_held_valid", bus.out_valid, 1);
        chk("t3_held_product", bus.out_product, 1);
        chk("t3_state_hold", bus.dbg_state, HOLD);
        bus.out_ready = 1'b1;
        wait_drain("t3_drain");
        wait fork;

        // Stuck multiplier: timeout result
        ovr_en   = 1'b1;
        ovr_done = 1'b0;
        push_op(9, 9, {1'b1, {PW{1'b0}}}, 1);
        wait_start("t4_start");
        n = 0;
        while (!bus.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("t4_timeout_latency", n, TIMEOUT);
        wait_drain("t4_drain");

        // Done held high across operations
        push_op(2, 3, res(6), 1);
        wait_start("t5_start1");
        repeat (6) @(negedge clk);
        ovr_done = 1'b1;
        wait_drain("t5_drain1");
        push_op(-128, -128, res(16384), 1);
        wait_start("t5_start2");
        highs = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid) highs++;
        end
        chk("t5_no_stale_completion", highs, 0);
        ovr_done = 1'b0;
        repeat (2) @(negedge clk);
        ovr_done = 1'b1;
        wait_drain("t5_drain2");
        ovr_done = 1'b0;

        // Reset mid-operation with entries queued
        for (int i = 0; i < 3; i++) push_op(7, 7, res(49), 0);
        n = 0;
        while (!(bus.dbg_state == WAIT && bus.fifo_count == 2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("t6_wait_with_two_queued", bus.fifo_count, 2);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rst_fifo_count", bus.fifo_count, 0);
        chk("t6_rst_out_valid", bus.out_valid, 0);
        chk("t6_rst_mul_start", bus.mul_start, 0);
        chk("t6_rst_state", bus.dbg_state, IDLE);
        rst = 1'b0;
        @(negedge clk);
        ovr_done = 1'b1;
        highs = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.out_valid || bus.mul_start) highs++;
        end
        chk("t6_late_done_ignored", highs, 0);
        ovr_done = 1'b0;
        chk("final_queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/booth_mul_sequencer.md
Name: booth_mul_sequencer

Overview:
Sits directly upstream of booth_multiplier and drives its start/a/b inputs.
- Buffers signed operand pairs from a valid/ready producer in a small FIFO.
- Issues one multiply at a time, waits for the multiplier's done, then presents the product on a valid/ready output.
- Flags a timeout if done never arrives, so a stuck multiplier cannot hang the datapath.

Parameters:
DATAWIDTH, 8, operand width; product width is 2*DATAWIDTH
FIFO_DEPTH, 4, operand FIFO entries; power of two, >= 2
TIMEOUT, 64, maximum cycles spent in WAIT before the timeout result is produced

Ports:
clk  in  1  clock, rising edge
rst_overall  in  1  asynchronous, active-high reset
in_valid  in  1  operand pair valid
in_ready  out  1  FIFO can accept; equals !full
in_a  in  DATAWIDTH  signed multiplicand
in_b  in  DATAWIDTH  signed multiplier
mul_start  out  1  one-cycle start pulse to booth_multiplier
mul_a  out  DATAWIDTH  operand a to booth_multiplier
mul_b  out  DATAWIDTH  operand b to booth_multiplier
mul_product  in  2*DATAWIDTH  signed product from booth_multiplier
mul_done  in  1  done from booth_multiplier; pulse or level
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
out_product  out  2*DATAWIDTH  signed result
out_timeout  out  1  qualifies out_valid: result produced by timeout
fifo_count  out  $clog2(FIFO_DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (async, active-high): FIFO emptied and fifo_count=0; state IDLE; mul_start=0; mul_a=0; mul_b=0; out_valid=0; out_product=0; out_timeout=0; done_q=0; timer=0. All outputs are registered.
- FIFO:
  - Push when in_valid && in_ready. Pop only on entry to ISSUE.
  - Push and pop in the same cycle are both honoured; count is unchanged.
  - in_ready is 0 when full. in_valid while full is ignored; no overwrite.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if the FIFO is non-empty, pop the head, load it into mul_a/mul_b, and go to ISSUE.
  - ISSUE: mul_start=1 for exactly this one cycle; clear the timer; go to WAIT.
  - WAIT: mul_a/mul_b stay stable.
    - Completion is mul_done rising: mul_done && !done_q.
    - On completion, capture mul_product into out_product, set out_timeout=0 and out_valid=1, and go to HOLD.
    - If the timer reaches TIMEOUT-1 with no completion, set out_product=0, out_timeout=1 and out_valid=1, and go to HOLD.
    - If completion and timer expiry fall in the same cycle, completion wins.
  - HOLD: out_valid, out_product and out_timeout stay stable until out_ready.
    - On handshake, clear out_valid.
    - If the FIFO is non-empty, pop and go directly to ISSUE. Otherwise go to IDLE.
- done_q samples mul_done every cycle in every state. A done already high from the previous operation is not a completion; completion needs mul_done to fall and rise again.
- mul_done edges outside WAIT are ignored.
- Latency: the earliest mul_start is asserted 2 cycles after the accepting in_valid edge. out_valid rises 1 cycle after the completing mul_done edge.
- Ordering: results leave strictly in operand arrival order. Only one multiply is in flight at a time.
- Arithmetic: no width change. The product is passed through verbatim as signed 2*DATAWIDTH.
- Reset mid-operation drops any in-flight multiply and all queued entries. A late mul_done after reset produces no output.

Decomposition:
- Package booth_seq_pkg: state enum (IDLE, ISSUE, WAIT, HOLD), PROD_W=2*DATAWIDTH, and a packed struct {a, b} used as the FIFO entry type.
- Sub-module booth_operand_fifo: synchronous FIFO with reset, push/pop/full/empty/count, parameterised by DATAWIDTH and FIFO_DEPTH.

Test Plan:
1. Reset, then push (5,3) with out_ready=1 → mul_start high for exactly 1 cycle, 2 cycles after the push; mul_a=5, mul_b=3; after mul_done, out_product=15 and out_timeout=0.
2. Push (-5,3), (5,-3), (-5,-3), (127,-128) back-to-back, out_ready=1 → outputs -15, -15, 15, -16256, in order; exactly one mul_start per pair.
3. Hold out_ready=0 and push 6 pairs → first result held in HOLD; FIFO fills to 4; in_ready=0; 6th pair stalls. Release out_ready → all 6 results emerge in order.
4. Multiplier model never asserts done → out_valid exactly TIMEOUT=64 cycles after entering WAIT, with out_timeout=1 and out_product=0.
5. Model holds done high after op 1 and then issues op 2 (-128,-128) → no completion until done falls and rises; then out_product=16384.
6. Assert rst_overall in WAIT with 2 entries queued → fifo_count=0, out_valid=0, mul_start=0; a mul_done after reset release yields no out_valid.
